// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage: FSM state encoding, bubble word, PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        RST_S = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// IF-stage bundle: hazard controls, IMEM request/response, IF/ID outputs and perf counters.
interface fetch_if;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_data;
    logic [31:0] d_ir;
    logic [31:0] d_pc;
    logic [31:0] d_pc4;
    logic        d_valid;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        input  stall, flush, redirect_pc, imem_rdy, imem_data,
        output imem_req, imem_addr, d_ir, d_pc, d_pc4, d_valid, stall_cnt, flush_cnt
    );

    modport slave (
        output stall, flush, redirect_pc, imem_rdy, imem_data,
        input  imem_req, imem_addr, d_ir, d_pc, d_pc4, d_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter; only built when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);
    logic [31:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != 32'hFFFF_FFFF)) begin
            cnt_reg <= cnt_reg + 32'd1;
        end
    end

    assign cnt = cnt_reg;
endmodule
`endif

// File: rtl/fetch_unit.sv
// IF stage with IF/ID register: one IMEM request in flight, STALL/FLUSH handling.
// Optional stall/flush perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  hold_ir_reg;
    logic [31:0]  hold_pc_reg;
    logic [31:0]  ir_reg;
    logic [31:0]  dpc_reg;
    logic         valid_reg;
    logic         flush_pend_reg;
    logic         flush_act;

    // FLUSH is ignored during the single post-reset cycle
    assign flush_act = bus.flush && (state_reg != RST_S);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RST_S;
            pc_reg         <= RESET_VEC;
            hold_ir_reg    <= NOP_INSTR;
            hold_pc_reg    <= '0;
            ir_reg         <= NOP_INSTR;
            dpc_reg        <= '0;
            valid_reg      <= 1'b0;
            flush_pend_reg <= 1'b0;
        end else begin
            if (flush_act || !bus.stall) begin
                ir_reg    <= NOP_INSTR;
                valid_reg <= 1'b0;
            end
            if (flush_act) begin
                pc_reg <= bus.redirect_pc;
            end
            case (state_reg)
                RST_S: state_reg <= REQ;
                REQ: begin
                    state_reg <= WAIT;
                    if (flush_act) flush_pend_reg <= 1'b1;
                end
                WAIT: begin
                    if (bus.imem_rdy) begin
                        flush_pend_reg <= 1'b0;
                        if (flush_pend_reg || flush_act) begin
                            state_reg <= REQ;
                        end else if (!bus.stall) begin
                            ir_reg    <= bus.imem_data;
                            dpc_reg   <= pc_reg;
                            valid_reg <= 1'b1;
                            pc_reg    <= pc_reg + PC_STEP;
                            state_reg <= REQ;
                        end else begin
                            hold_ir_reg <= bus.imem_data;
                            hold_pc_reg <= pc_reg;
                            state_reg   <= HOLD;
                        end
                    end else if (flush_act) begin
                        flush_pend_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush_act) begin
                        state_reg <= REQ;
                    end else if (!bus.stall) begin
                        ir_reg    <= hold_ir_reg;
                        dpc_reg   <= hold_pc_reg;
                        valid_reg <= 1'b1;
                        pc_reg    <= pc_reg + PC_STEP;
                        state_reg <= REQ;
                    end
                end
                default: state_reg <= RST_S;
            endcase
        end
    end

    assign bus.imem_req  = (state_reg == REQ);
    assign bus.imem_addr = pc_reg;
    assign bus.d_ir      = ir_reg;
    assign bus.d_pc      = dpc_reg;
    assign bus.d_pc4     = dpc_reg + PC_STEP;
    assign bus.d_valid   = valid_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [1:0]  cnt_inc;
    logic [31:0] cnt_val [2];

    assign cnt_inc = {bus.flush, bus.stall};

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        fetch_perf_cnt u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (cnt_inc[gi]),
            .cnt (cnt_val[gi])
        );
    end

    assign bus.stall_cnt = cnt_val[0];
    assign bus.flush_cnt = cnt_val[1];
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level program-order model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd5;
    localparam logic [31:0] FLUSH_EXP = 32'd2;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
    localparam logic [31:0] FLUSH_EXP = 32'd0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    fetch_if ifa();
    fetch_if ifb();

    fetch_unit u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.master)
    );

    fetch_unit #(.RESET_VEC(32'hFFFF_FFFC)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int lat_a = 1, lat_b = 1;
    int cnt_a = 0, cnt_b = 0;
    logic [31:0] raddr_a = '0, raddr_b = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_000A;
        if (a == 32'h4) return 32'h0000_000B;
        return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
    endfunction

    // Advance one clock; sample point is 1ns after the edge. Also plays IMEM for both DUTs.
    task automatic tick();
        @(posedge clk);
        #1;
        ifa.imem_rdy = 1'b0;
        ifb.imem_rdy = 1'b0;
        if (rst_a) cnt_a = 0;
        else if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) begin ifa.imem_rdy = 1'b1; ifa.imem_data = mem_word(raddr_a); end
        end
        if (!rst_a && ifa.imem_req) begin
            n_cmp++;
            if (cnt_a != 0) begin n_bad++; $display("FAIL inflight_a: req while %0d cycles outstanding, required none", cnt_a); end
            cnt_a = lat_a; raddr_a = ifa.imem_addr;
        end
        if (rst_b) cnt_b = 0;
        else if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) begin ifb.imem_rdy = 1'b1; ifb.imem_data = mem_word(raddr_b); end
        end
        if (!rst_b && ifb.imem_req) begin
            cnt_b = lat_b; raddr_b = ifb.imem_addr;
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; ifa.stall = 1'b0; ifa.flush = 1'b0; ifa.redirect_pc = '0; lat_a = 1;
        tick(); tick();
        n_cmp++; if (ifa.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", ifa.imem_req); end
        n_cmp++; if (ifa.d_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ifa.d_valid); end
        n_cmp++; if (ifa.d_ir !== NOP) begin n_bad++; $display("FAIL reset_ir: got %h want %h", ifa.d_ir, NOP); end
        n_cmp++; if (ifa.d_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", ifa.d_pc); end
        n_cmp++; if (ifa.stall_cnt !== 32'h0 || ifa.flush_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_cnt: got %h/%h want 0/0", ifa.stall_cnt, ifa.flush_cnt); end
        rst_a = 1'b0;
        tick();
        n_cmp++; if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_req: got req=%b addr=%h want 1/0", ifa.imem_req, ifa.imem_addr); end
        n_cmp++; if (ifa.d_valid !== 1'b0 || ifa.d_ir !== NOP) begin n_bad++; $display("FAIL first_idle: got v=%b ir=%h want 0/%h", ifa.d_valid, ifa.d_ir, NOP); end
        $display("txn reset done");
    endtask

    task automatic test_stream();
        tick();
        n_cmp++; if (ifa.d_valid !== 1'b0) begin n_bad++; $display("FAIL stream_wait: got v=%b want 0", ifa.d_valid); end
        tick();
        n_cmp++; if (ifa.d_ir !== 32'hA || ifa.d_pc !== 32'h0 || ifa.d_valid !== 1'b1 || ifa.d_pc4 !== 32'h4) begin n_bad++; $display("FAIL stream_a: got ir=%h pc=%h pc4=%h v=%b want a/0/4/1", ifa.d_ir, ifa.d_pc, ifa.d_pc4, ifa.d_valid); end
        tick();
        n_cmp++; if (ifa.d_valid !== 1'b0 || ifa.d_ir !== NOP) begin n_bad++; $display("FAIL stream_bubble: got v=%b ir=%h want 0/%h", ifa.d_valid, ifa.d_ir, NOP); end
        tick();
        n_cmp++; if (ifa.d_ir !== 32'hB || ifa.d_pc !== 32'h4 || ifa.d_pc4 !== 32'h8 || ifa.d_valid !== 1'b1) begin n_bad++; $display("FAIL stream_b: got ir=%h pc=%h pc4=%h v=%b want b/4/8/1", ifa.d_ir, ifa.d_pc, ifa.d_pc4, ifa.d_valid); end
        n_cmp++; if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== 32'h8) begin n_bad++; $display("FAIL stream_next: got req=%b addr=%h want 1/8", ifa.imem_req, ifa.imem_addr); end
        $display("txn stream done");
    endtask

    task automatic test_stall();
        ifa.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ifa.d_ir !== 32'hB || ifa.d_pc !== 32'h4 || ifa.d_valid !== 1'b1 || ifa.imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_freeze%0d: got ir=%h pc=%h v=%b req=%b want b/4/1/0", i, ifa.d_ir, ifa.d_pc, ifa.d_valid, ifa.imem_req); end
        end
        ifa.stall = 1'b0; lat_a = 3;
        tick();
        n_cmp++; if (ifa.d_ir !== mem_word(32'h8) || ifa.d_pc !== 32'h8 || ifa.d_valid !== 1'b1) begin n_bad++; $display("FAIL stall_release: got ir=%h pc=%h v=%b want %h/8/1", ifa.d_ir, ifa.d_pc, ifa.d_valid, mem_word(32'h8)); end
        n_cmp++; if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== 32'hC) begin n_bad++; $display("FAIL stall_next: got req=%b addr=%h want 1/c", ifa.imem_req, ifa.imem_addr); end
        $display("txn stall done");
    endtask

    task automatic test_flush_wait();
        tick();
        ifa.flush = 1'b1; ifa.redirect_pc = 32'h100;
        tick();
        n_cmp++; if (ifa.d_valid !== 1'b0 || ifa.d_ir !== NOP) begin n_bad++; $display("FAIL flush_bubble: got v=%b ir=%h want 0/%h", ifa.d_valid, ifa.d_ir, NOP); end
        ifa.flush = 1'b0;
        tick();
        lat_a = 1;
        tick();
        n_cmp++; if (ifa.d_valid !== 1'b0 || ifa.d_ir !== NOP) begin n_bad++; $display("FAIL flush_late_rdy: got v=%b ir=%h want 0/%h", ifa.d_valid, ifa.d_ir, NOP); end
        n_cmp++; if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== 32'h100) begin n_bad++; $display("FAIL flush_redirect: got req=%b addr=%h want 1/100", ifa.imem_req, ifa.imem_addr); end
        tick(); tick();
        n_cmp++; if (ifa.d_ir !== mem_word(32'h100) || ifa.d_pc !== 32'h100 || ifa.d_valid !== 1'b1) begin n_bad++; $display("FAIL flush_target: got ir=%h pc=%h v=%b want %h/100/1", ifa.d_ir, ifa.d_pc, ifa.d_valid, mem_word(32'h100)); end
        $display("txn flush_wait done");
    endtask

    task automatic test_flush_stall_hold();
        ifa.stall = 1'b1;
        tick(); tick();
        n_cmp++; if (ifa.d_ir !== mem_word(32'h100) || ifa.d_valid !== 1'b1 || ifa.imem_req !== 1'b0) begin n_bad++; $display("FAIL hold_freeze: got ir=%h v=%b req=%b want %h/1/0", ifa.d_ir, ifa.d_valid, ifa.imem_req, mem_word(32'h100)); end
        ifa.flush = 1'b1; ifa.redirect_pc = 32'h200;
        tick();
        n_cmp++; if (ifa.imem_req !== 1'b1 || ifa.imem_addr !== 32'h200) begin n_bad++; $display("FAIL hold_redirect: got req=%b addr=%h want 1/200", ifa.imem_req, ifa.imem_addr); end
        n_cmp++; if (ifa.d_valid !== 1'b0 || ifa.d_ir !== NOP) begin n_bad++; $display("FAIL hold_bubble: got v=%b ir=%h want 0/%h", ifa.d_valid, ifa.d_ir, NOP); end
        ifa.flush = 1'b0; ifa.stall = 1'b0;
        tick(); tick();
        n_cmp++; if (ifa.d_ir !== mem_word(32'h200) || ifa.d_pc !== 32'h200 || ifa.d_valid !== 1'b1) begin n_bad++; $display("FAIL hold_target: got ir=%h pc=%h v=%b want %h/200/1", ifa.d_ir, ifa.d_pc, ifa.d_valid, mem_word(32'h200)); end
        $display("txn flush_stall_hold done");
    endtask

    task automatic test_wrap_counters();
        rst_b = 1'b1; lat_b = 1;
        tick(); tick();
        rst_b = 1'b0;
        tick();
        n_cmp++; if (ifb.imem_req !== 1'b1 || ifb.imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", ifb.imem_req, ifb.imem_addr); end
        tick(); tick();
        n_cmp++; if (ifb.d_pc !== 32'hFFFF_FFFC || ifb.d_pc4 !== 32'h0 || ifb.d_ir !== mem_word(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_dpc: got pc=%h pc4=%h ir=%h want fffffffc/0/%h", ifb.d_pc, ifb.d_pc4, ifb.d_ir, mem_word(32'hFFFF_FFFC)); end
        n_cmp++; if (ifb.imem_req !== 1'b1 || ifb.imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_second: got req=%b addr=%h want 1/0", ifb.imem_req, ifb.imem_addr); end
        ifb.stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (ifb.stall_cnt !== STALL_EXP) begin n_bad++; $display("FAIL stall_cnt: got %0d want %0d", ifb.stall_cnt, STALL_EXP); end
        ifb.stall = 1'b0; ifb.flush = 1'b1; ifb.redirect_pc = 32'h40;
        tick(); tick();
        n_cmp++; if (ifb.flush_cnt !== FLUSH_EXP || ifb.stall_cnt !== STALL_EXP) begin n_bad++; $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d", ifb.flush_cnt, ifb.stall_cnt, FLUSH_EXP, STALL_EXP); end
        ifb.flush = 1'b0;
        $display("txn wrap_counters done");
    endtask

    // Program-order model: every new IF/ID entry must be the next sequential PC,
    // restarting at the redirect target after each flush.
    task automatic test_random();
        logic [31:0] exp_pc, m_ir, m_pc, pr;
        logic        m_valid, pc_known, ps, pf;
        int          deliveries;
        rst_a = 1'b1; ifa.stall = 1'b0; ifa.flush = 1'b0;
        tick(); tick();
        rst_a = 1'b0;
        exp_pc = 32'h0; m_ir = NOP; m_pc = 32'h0; m_valid = 1'b0; pc_known = 1'b1; deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            ifa.stall = ($urandom_range(0, 3) == 0);
            ifa.flush = (c >= 3) && ($urandom_range(0, 11) == 0);
            ifa.redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            lat_a = $urandom_range(1, 3);
            ps = ifa.stall; pf = ifa.flush; pr = ifa.redirect_pc;
            tick();
            if (pf) begin
                n_cmp++; if (ifa.d_valid !== 1'b0 || ifa.d_ir !== NOP) begin n_bad++; $display("FAIL rnd_flush c=%0d: got v=%b ir=%h want 0/%h", c, ifa.d_valid, ifa.d_ir, NOP); end
                exp_pc = pr; m_ir = NOP; m_valid = 1'b0; pc_known = 1'b0;
            end else if (ps) begin
                n_cmp++; if (ifa.d_valid !== m_valid || ifa.d_ir !== m_ir || (pc_known && ifa.d_pc !== m_pc)) begin n_bad++; $display("FAIL rnd_stall c=%0d: got v=%b ir=%h pc=%h want %b/%h/%h", c, ifa.d_valid, ifa.d_ir, ifa.d_pc, m_valid, m_ir, m_pc); end
            end else if (ifa.d_valid === 1'b1) begin
                n_cmp++; if (ifa.d_pc !== exp_pc || ifa.d_ir !== mem_word(exp_pc) || ifa.d_pc4 !== exp_pc + 32'd4) begin n_bad++; $display("FAIL rnd_deliver c=%0d: got pc=%h ir=%h pc4=%h want %h/%h/%h", c, ifa.d_pc, ifa.d_ir, ifa.d_pc4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4); end
                $display("txn c=%0d pc=%h ir=%h", c, exp_pc, mem_word(exp_pc));
                m_ir = mem_word(exp_pc); m_pc = exp_pc; m_valid = 1'b1; pc_known = 1'b1;
                exp_pc = exp_pc + 32'd4; deliveries++;
            end else begin
                n_cmp++; if (ifa.d_ir !== NOP || (pc_known && ifa.d_pc !== m_pc)) begin n_bad++; $display("FAIL rnd_bubble c=%0d: got ir=%h pc=%h want %h/%h", c, ifa.d_ir, ifa.d_pc, NOP, m_pc); end
                m_ir = NOP; m_valid = 1'b0;
            end
        end
        ifa.stall = 1'b0; ifa.flush = 1'b0;
        n_cmp++; if (deliveries < 200) begin n_bad++; $display("FAIL rnd_progress: got %0d deliveries want >=200", deliveries); end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.stall = 1'b0; ifa.flush = 1'b0; ifa.redirect_pc = '0; ifa.imem_rdy = 1'b0; ifa.imem_data = '0;
        ifb.stall = 1'b0; ifb.flush = 1'b0; ifb.redirect_pc = '0; ifb.imem_rdy = 1'b0; ifb.imem_data = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush_wait();
        test_flush_stall_hold();
        test_wrap_counters();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
